// File: rtl/vx_launch_ctrl.sv
// vx_launch_ctrl: bus-mapped launch sequencer holding one Vortex in reset
// until START, then timed release, busy tracking, cycle count and done irq.
// Ports: clk, reset (async, active-low), bus_sel/bus_write/bus_addr/
//   bus_wdata in, bus_rdata/bus_ready out, vx_reset out, vx_busy in, irq out.
// Optional watchdog: define VX_LAUNCH_TIMEOUT_EN.
module vx_launch_ctrl #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFFF0,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_sel,
  input  logic              bus_write,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ready,
  output logic              vx_reset,
  input  logic              vx_busy,
  output logic              irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t state, state_n;
  logic [7:0] hold_cnt, hold_n;
  logic [CNT_W-1:0] cycles, cyc_n, cyc_inc;
  logic done, done_n;
  logic tmo, tmo_n;
  logic seen, seen_n;
  logic busy_q;
  logic irq_en;
  logic in_win;
  logic [1:0] off;
  logic ctrl_wr, start, abort, clr;
  logic [31:0] rd_val;
  logic unused;

`ifdef VX_LAUNCH_TIMEOUT_EN
  logic [CNT_W-1:0] timeout_q;
`endif

  assign unused = ^{bus_wdata, bus_addr};

  assign in_win = bus_addr[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4];
  assign off = bus_addr[3:2];
  assign ctrl_wr = bus_sel & bus_write & in_win & (off == 2'd0);
  // ABORT in the same write suppresses START everywhere
  assign start = ctrl_wr & bus_wdata[0] & ~bus_wdata[1];
  assign abort = ctrl_wr & bus_wdata[1];
  assign clr = ctrl_wr & bus_wdata[2];

  assign cyc_inc = (cycles == '1) ? cycles : cycles + 1'b1;

  assign vx_reset = (state != RUN);
  assign irq = irq_en & (done | tmo);

  always_comb begin
    state_n = state;
    hold_n = hold_cnt;
    cyc_n = cycles;
    // a completion event below overrides the clear
    done_n = done & ~clr;
    tmo_n = tmo & ~clr;
    seen_n = seen;
    unique case (state)
      IDLE, FIN: begin
        if (start) begin
          state_n = HOLD;
          hold_n = '0;
          cyc_n = '0;
          done_n = 1'b0;
          tmo_n = 1'b0;
          seen_n = 1'b0;
        end
      end
      HOLD: begin
        if (abort) state_n = FIN;
        else if (hold_cnt == 8'(HOLD_CYCLES - 1)) state_n = RUN;
        else hold_n = hold_cnt + 8'd1;
      end
      RUN: begin
        cyc_n = cyc_inc;
        if (vx_busy) seen_n = 1'b1;
        if (abort) begin
          state_n = FIN;
        end else begin
          if (!busy_q && seen) begin
            done_n = 1'b1;
            state_n = FIN;
          end
`ifdef VX_LAUNCH_TIMEOUT_EN
          if (timeout_q != '0 && cyc_inc == timeout_q) begin
            tmo_n = 1'b1;
            state_n = FIN;
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (in_win) begin
      unique case (off)
        2'd1: rd_val = {26'd0, state, irq_en, tmo, done, busy_q};
        2'd2: rd_val = 32'(cycles);
`ifdef VX_LAUNCH_TIMEOUT_EN
        2'd3: rd_val = 32'(timeout_q);
`endif
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      cycles <= '0;
      done <= 1'b0;
      tmo <= 1'b0;
      seen <= 1'b0;
      busy_q <= 1'b0;
      irq_en <= 1'b0;
      bus_ready <= 1'b0;
      bus_rdata <= '0;
    end else begin
      state <= state_n;
      hold_cnt <= hold_n;
      cycles <= cyc_n;
      done <= done_n;
      tmo <= tmo_n;
      seen <= seen_n;
      busy_q <= vx_busy;
      if (ctrl_wr) irq_en <= bus_wdata[3];
      bus_ready <= bus_sel;
      bus_rdata <= (bus_sel && !bus_write) ? rd_val : '0;
    end
  end

`ifdef VX_LAUNCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timeout_q <= '0;
    else if (bus_sel && bus_write && in_win && off == 2'd3)
      timeout_q <= bus_wdata[CNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_vx_launch_ctrl.sv
// tb_vx_launch_ctrl: randomized self-checking bench for vx_launch_ctrl.
// Expected values come from run-length arithmetic on the driven busy pattern.
module tb_vx_launch_ctrl;

  localparam int HOLD = 8;
  localparam logic [15:0] A_CTRL = 16'hFFF0;
  localparam logic [15:0] A_STAT = 16'hFFF4;
  localparam logic [15:0] A_CYC = 16'hFFF8;
  localparam logic [15:0] A_TMO = 16'hFFFC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bus_sel = 1'b0;
  logic bus_write = 1'b0;
  logic [15:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic bus_ready;
  logic vx_reset;
  logic vx_busy = 1'b0;
  logic irq;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vx_launch_ctrl #(
    .ADDR_W(16),
    .BASE_ADDR(16'hFFF0),
    .HOLD_CYCLES(HOLD),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_sel(bus_sel),
    .bus_write(bus_write),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready),
    .vx_reset(vx_reset),
    .vx_busy(vx_busy),
    .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int st, input logic en,
                                       input logic to, input logic dn,
                                       input logic bz);
    return {26'd0, 2'(st), en, to, dn, bz};
  endfunction

  // called at a negedge; returns at the negedge after the access edge
  task automatic bus(input logic wr, input logic [15:0] a,
                     input logic [31:0] d, output logic [31:0] q);
    bus_sel = 1'b1;
    bus_write = wr;
    bus_addr = a;
    bus_wdata = d;
    @(negedge clk);
    bus_sel = 1'b0;
    bus_write = 1'b0;
    q = bus_rdata;
    chk("ready", {31'd0, bus_ready}, 32'd1);
  endtask

  // returns at the negedge of the first RUN cycle
  task automatic start_run(input logic en);
    logic [31:0] q;
    int h;
    bus(1'b1, A_CTRL, {28'd0, en, 3'b001}, q);
    h = 0;
    while (vx_reset && h < 1000) begin
      @(negedge clk);
      h++;
    end
    chk("hold_len", h, HOLD);
  endtask

  // busy high during RUN cycles D+1..D+B, then done after D+B+2 cycles
  task automatic run_done(input int d, input int b, input logic en);
    logic [31:0] q;
    start_run(en);
    repeat (d) @(negedge clk);
    vx_busy = 1'b1;
    repeat (b) @(negedge clk);
    vx_busy = 1'b0;
    @(negedge clk);
    chk("irq_pre", {31'd0, irq}, 32'd0);
    chk("vxrst_pre", {31'd0, vx_reset}, 32'd0);
    @(negedge clk);
    chk("irq_done", {31'd0, irq}, {31'd0, en});
    chk("vxrst_done", {31'd0, vx_reset}, 32'd1);
    bus(1'b0, A_STAT, 0, q);
    chk("stat_done", q, stat(3, en, 1'b0, 1'b1, 1'b0));
    bus(1'b0, A_CYC, 0, q);
    chk("cyc_done", q, 32'(d + b + 2));
  endtask

  initial begin
    logic [31:0] q;
    int n;
    logic en;

    #12;
    chk("rst_vxrst", {31'd0, vx_reset}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_ready", {31'd0, bus_ready}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus(1'b0, A_STAT, 0, q);
    chk("rst_stat", q, 32'd0);
    bus(1'b0, A_CYC, 0, q);
    chk("rst_cyc", q, 32'd0);
    bus(1'b0, A_TMO, 0, q);
    chk("rst_tmo", q, 32'd0);

    run_done(0, 100, 1'b1);

    bus(1'b1, A_CTRL, 32'hC, q);
    bus(1'b0, A_STAT, 0, q);
    chk("clr_stat", q, stat(3, 1'b1, 1'b0, 1'b0, 1'b0));
    chk("clr_irq", {31'd0, irq}, 32'd0);

    bus(1'b0, 16'h7FF8, 0, q);
    chk("oow_rd", q, 32'd0);

    for (int i = 0; i < 4; i++) begin
      en = 1'($urandom_range(0, 1));
      run_done(int'($urandom_range(0, 5)), int'($urandom_range(1, 40)), en);
    end

    start_run(1'b1);
    vx_busy = 1'b1;
    repeat (3) @(negedge clk);
    bus(1'b0, A_CYC, 0, q);
    chk("cyc_run_a", q, 32'd3);
    bus(1'b1, A_CTRL, 32'h9, q);
    bus(1'b0, A_CYC, 0, q);
    chk("cyc_run_b", q, 32'd5);
    bus(1'b0, A_STAT, 0, q);
    chk("stat_run", q, stat(2, 1'b1, 1'b0, 1'b0, 1'b1));
    bus(1'b1, A_CTRL, 32'h2, q);
    bus(1'b0, A_STAT, 0, q);
    chk("stat_abort", q, stat(3, 1'b0, 1'b0, 1'b0, 1'b1));
    chk("vxrst_abort", {31'd0, vx_reset}, 32'd1);
    bus(1'b0, A_CYC, 0, q);
    chk("cyc_abort", q, 32'd8);
    vx_busy = 1'b0;
    @(negedge clk);

    start_run(1'b1);
    vx_busy = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_vxrst", {31'd0, vx_reset}, 32'd1);
    chk("mid_irq", {31'd0, irq}, 32'd0);
    chk("mid_ready", {31'd0, bus_ready}, 32'd0);
    chk("mid_rdata", bus_rdata, 32'd0);
    vx_busy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus(1'b0, A_STAT, 0, q);
    chk("mid_stat", q, 32'd0);
    bus(1'b0, A_CYC, 0, q);
    chk("mid_cyc", q, 32'd0);

    bus(1'b1, A_CTRL, 32'h3, q);
    repeat (3) @(negedge clk);
    bus(1'b0, A_STAT, 0, q);
    chk("sa_stat", q, 32'd0);
    chk("sa_vxrst", {31'd0, vx_reset}, 32'd1);

    bus(1'b1, 16'h0000, 32'h1, q);
    repeat (3) @(negedge clk);
    bus(1'b0, A_STAT, 0, q);
    chk("oow_wr", q, 32'd0);

`ifdef VX_LAUNCH_TIMEOUT_EN
    bus(1'b1, A_TMO, 32'd50, q);
    bus(1'b0, A_TMO, 0, q);
    chk("tmo_rb", q, 32'd50);
    start_run(1'b1);
    vx_busy = 1'b1;
    n = 0;
    while (!vx_reset && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wd_runlen", n, 50);
    chk("wd_irq", {31'd0, irq}, 32'd1);
    bus(1'b0, A_STAT, 0, q);
    chk("wd_stat", q, stat(3, 1'b1, 1'b1, 1'b0, 1'b1));
    bus(1'b0, A_CYC, 0, q);
    chk("wd_cyc", q, 32'd50);
    vx_busy = 1'b0;
`else
    n = 0;
    bus(1'b1, A_TMO, 32'd50, q);
    bus(1'b0, A_TMO, 0, q);
    chk("tmo_off", q, 32'(n));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
